// File: rtl/branch_predictor_unit.sv
// Dynamic branch predictor: tagged BTB plus saturating direction counters, indexed
// bimodally (PC) or gshare (PC ^ history). Self-clearing tables and a mispredict counter.
module branch_predictor_unit #(
  parameter int ENTRIES = 32,
  parameter int PC_W    = 32,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 8,
  parameter int MODE    = 0,
  parameter int MISS_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  output logic              ready,
  input  logic [PC_W-1:0]   pred_pc,
  output logic              pred_taken,
  output logic              pred_hit,
  output logic [PC_W-1:0]   pred_target,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_mispredict,
  output logic [MISS_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(1) << (CNT_W - 2);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   init_idx_reg, init_idx_next;
  logic               init_we;
  logic [GHR_W-1:0]   ghr_reg;
  logic [MISS_W-1:0]  miss_reg;

  logic               btb_valid  [ENTRIES];
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [PC_W-1:0]    btb_target [ENTRIES];
  logic [CNT_W-1:0]   cnt        [ENTRIES];

  logic [IDX_W-1:0]   pred_bidx, pred_cidx, upd_bidx, upd_cidx;
  logic [TAG_W-1:0]   pred_tag, upd_tag;
  logic [CNT_W-1:0]   upd_cnt_cur, upd_cnt_next;
  logic               do_upd;
  logic               unused_bits;

  assign ready      = (state_reg == S_RUN);
  assign pred_ghr   = ghr_reg;
  assign miss_count = miss_reg;
  assign do_upd     = upd_valid & ready;

  // Prediction path: purely combinational reads of the current table contents.
  assign pred_bidx   = pred_pc[IDX_W+1:2];
  assign pred_tag    = pred_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign pred_cidx   = (MODE == 1) ? (pred_bidx ^ ghr_reg[IDX_W-1:0]) : pred_bidx;
  assign pred_hit    = ready & btb_valid[pred_bidx] & (btb_tag[pred_bidx] == pred_tag);
  assign pred_taken  = pred_hit & cnt[pred_cidx][CNT_W-1];
  assign pred_target = btb_target[pred_bidx];

  // Updates index with the history seen at prediction time, not the live register.
  assign upd_bidx    = upd_pc[IDX_W+1:2];
  assign upd_tag     = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_cidx    = (MODE == 1) ? (upd_bidx ^ upd_ghr[IDX_W-1:0]) : upd_bidx;
  assign upd_cnt_cur = cnt[upd_cidx];

  always_comb begin
    upd_cnt_next = upd_cnt_cur;
    if (upd_taken) begin
      if (upd_cnt_cur != CNT_MAX) upd_cnt_next = upd_cnt_cur + 1'b1;
    end else if (upd_cnt_cur != '0) begin
      upd_cnt_next = upd_cnt_cur - 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_idx_next = init_idx_reg;
    init_we       = 1'b0;
    case (state_reg)
      S_INIT: begin
        init_we = 1'b1;
        if (flush) begin
          init_idx_next = '0;
        end else if (init_idx_reg == IDX_W'(ENTRIES - 1)) begin
          state_next    = S_RUN;
          init_idx_next = '0;
        end else begin
          init_idx_next = init_idx_reg + 1'b1;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_next    = S_INIT;
          init_idx_next = '0;
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_INIT;
      init_idx_reg <= '0;
      ghr_reg      <= '0;
      miss_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      init_idx_reg <= init_idx_next;
      if (do_upd) begin
        ghr_reg <= {ghr_reg[GHR_W-2:0], upd_taken};
        if (upd_mispredict && (miss_reg != '1)) miss_reg <= miss_reg + 1'b1;
      end
    end
  end

  // Table storage carries no reset; the init sequencer clears it instead.
  always_ff @(posedge clk) begin
    if (init_we) begin
      btb_valid[init_idx_reg] <= 1'b0;
      cnt[init_idx_reg]       <= CNT_WEAK_NT;
    end else if (do_upd) begin
      cnt[upd_cidx] <= upd_cnt_next;
      if (upd_taken) begin
        btb_valid[upd_bidx]  <= 1'b1;
        btb_tag[upd_bidx]    <= upd_tag;
        btb_target[upd_bidx] <= upd_target;
      end
    end
  end

  assign unused_bits = ^{pred_pc, upd_pc, upd_ghr};

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Scoreboard bench: a bimodal instance and a gshare instance share stimulus; sel picks
// which one receives updates and whose outputs are recorded.
module tb_branch_predictor_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        upd_valid0 = 1'b0, upd_valid1 = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;
  logic [7:0]  upd_ghr = '0;
  logic        upd_taken = 1'b0, upd_mispredict = 1'b0;

  logic        ready0, ready1, hit0, hit1, taken0, taken1;
  logic [31:0] tgt0, tgt1;
  logic [7:0]  ghr0, ghr1;
  logic [15:0] miss0, miss1;

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;

  logic [7:0]  ghr_m0 = '0, ghr_m1 = '0;
  logic [15:0] miss_m0 = '0;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } pred_t;

  pred_t exp_q[$];
  pred_t obs_q[$];

  always #5 clk = ~clk;

  branch_predictor_unit #(.MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready0),
    .pred_pc(pred_pc), .pred_taken(taken0), .pred_hit(hit0), .pred_target(tgt0),
    .pred_ghr(ghr0), .upd_valid(upd_valid0), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .miss_count(miss0)
  );

  branch_predictor_unit #(.MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .ready(ready1),
    .pred_pc(pred_pc), .pred_taken(taken1), .pred_hit(hit1), .pred_target(tgt1),
    .pred_ghr(ghr1), .upd_valid(upd_valid1), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .miss_count(miss1)
  );

  function automatic logic [1:0] cnt_step(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // One update on the selected instance; call at a falling edge, returns at the next.
  task automatic do_upd(input logic [31:0] pc, input logic [7:0] g, input logic t,
                        input logic [31:0] tgt, input logic mp);
    upd_pc = pc; upd_ghr = g; upd_taken = t; upd_target = tgt; upd_mispredict = mp;
    if (sel) upd_valid1 = 1'b1; else upd_valid0 = 1'b1;
    $display("upd  dut%0d pc=%h ghr=%h taken=%b tgt=%h misp=%b", sel, pc, g, t, tgt, mp);
    @(negedge clk);
    upd_valid0 = 1'b0;
    upd_valid1 = 1'b0;
  endtask

  // Pushes the expected prediction, drives the PC and records what the DUT shows.
  task automatic drive_pred(input string name, input logic [31:0] pc, input logic h,
                            input logic t, input logic [31:0] tgt);
    pred_t e, o;
    e.name = name; e.hit = h; e.taken = t; e.tgt = tgt;
    exp_q.push_back(e);
    pred_pc = pc;
    #1;
    o.name = name;
    o.hit   = sel ? hit1 : hit0;
    o.taken = sel ? taken1 : taken0;
    o.tgt   = sel ? tgt1 : tgt0;
    obs_q.push_back(o);
    $display("pred dut%0d %s pc=%h hit=%b taken=%b tgt=%h", sel, name, pc, o.hit, o.taken, o.tgt);
  endtask

  task automatic test_reset();
    pred_t e, o;
    #3;
    checks++;
    if ({ready0, ready1, miss0, ghr0, ghr1} !== '0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b%b miss=%0d ghr=%h/%h, want all zero",
               ready0, ready1, miss0, ghr0, ghr1);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    pred_pc = 32'h40;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ready0 !== (i == 32) || ready1 !== (i == 32) || (i < 32 && (hit0 | hit1) !== 1'b0)) begin
        errors++;
        $display("FAIL init_ready edge %0d: got ready=%b/%b hit=%b/%b, want ready=%b hit=0",
                 i, ready0, ready1, hit0, hit1, (i == 32));
      end
    end
    @(negedge clk);
    sel = 1'b0; drive_pred("post_init0", 32'h40, 1'b0, 1'b0, 32'h0);
    sel = 1'b1; drive_pred("post_init1", 32'h40, 1'b0, 1'b0, 32'h0);
    sel = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.hit !== e.hit || o.taken !== e.taken || (e.hit && o.tgt !== e.tgt)) begin
        errors++;
        $display("FAIL %s: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h",
                 e.name, o.hit, o.taken, o.tgt, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  logic [1:0] cm16;

  task automatic test_bimodal();
    pred_t e, o;
    @(negedge clk);
    sel = 1'b0;
    cm16 = 2'd1;
    do_upd(32'h40, ghr_m0, 1'b1, 32'h100, 1'b0);
    cm16 = cnt_step(cm16, 1'b1);
    ghr_m0 = {ghr_m0[6:0], 1'b1};
    drive_pred("bimodal_first", 32'h40, 1'b1, cm16[1], 32'h100);
    checks++;
    if (ghr0 !== ghr_m0) begin
      errors++;
      $display("FAIL bimodal_ghr: got %h, want %h", ghr0, ghr_m0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.hit !== e.hit || o.taken !== e.taken || (e.hit && o.tgt !== e.tgt)) begin
        errors++;
        $display("FAIL %s: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h",
                 e.name, o.hit, o.taken, o.tgt, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_saturation();
    pred_t e, o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      do_upd(32'h40, ghr_m0, 1'b1, 32'h100, 1'b0);
      cm16 = cnt_step(cm16, 1'b1);
      ghr_m0 = {ghr_m0[6:0], 1'b1};
      drive_pred($sformatf("sat_up%0d", i), 32'h40, 1'b1, cm16[1], 32'h100);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      do_upd(32'h40, ghr_m0, 1'b0, 32'h0, 1'b0);
      cm16 = cnt_step(cm16, 1'b0);
      ghr_m0 = {ghr_m0[6:0], 1'b0};
      drive_pred($sformatf("sat_dn%0d", i), 32'h40, 1'b1, cm16[1], 32'h100);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.hit !== e.hit || o.taken !== e.taken || (e.hit && o.tgt !== e.tgt)) begin
        errors++;
        $display("FAIL %s: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h",
                 e.name, o.hit, o.taken, o.tgt, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_alias();
    pred_t e, o;
    @(negedge clk);
    drive_pred("alias_miss", 32'hC0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    do_upd(32'hC0, ghr_m0, 1'b1, 32'h200, 1'b0);
    cm16 = cnt_step(cm16, 1'b1);
    ghr_m0 = {ghr_m0[6:0], 1'b1};
    drive_pred("alias_evicted", 32'h40, 1'b0, 1'b0, 32'h0);
    drive_pred("alias_new", 32'hC0, 1'b1, cm16[1], 32'h200);
    @(negedge clk);
    do_upd(32'hC0, ghr_m0, 1'b1, 32'h200, 1'b0);
    cm16 = cnt_step(cm16, 1'b1);
    ghr_m0 = {ghr_m0[6:0], 1'b1};
    drive_pred("alias_new2", 32'hC0, 1'b1, cm16[1], 32'h200);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.hit !== e.hit || o.taken !== e.taken || (e.hit && o.tgt !== e.tgt)) begin
        errors++;
        $display("FAIL %s: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h",
                 e.name, o.hit, o.taken, o.tgt, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_back_to_back();
    pred_t e, o;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      do_upd(32'h80 + 32'(4 * i), ghr_m0, 1'b1, 32'h300 + 32'(4 * i), 1'b0);
      ghr_m0 = {ghr_m0[6:0], 1'b1};
    end
    for (int i = 0; i < 3; i++)
      drive_pred($sformatf("b2b%0d", i), 32'h80 + 32'(4 * i), 1'b1, 1'b1, 32'h300 + 32'(4 * i));
    checks++;
    if (ghr0 !== ghr_m0) begin
      errors++;
      $display("FAIL b2b_ghr: got %h, want %h", ghr0, ghr_m0);
    end
    // Predict and update the same entry in one cycle: the old contents must show.
    @(negedge clk);
    upd_pc = 32'h8C; upd_ghr = ghr_m0; upd_taken = 1'b1; upd_target = 32'h30C;
    upd_mispredict = 1'b0; upd_valid0 = 1'b1;
    drive_pred("no_bypass_before", 32'h8C, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    upd_valid0 = 1'b0;
    ghr_m0 = {ghr_m0[6:0], 1'b1};
    drive_pred("no_bypass_after", 32'h8C, 1'b1, 1'b1, 32'h30C);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.hit !== e.hit || o.taken !== e.taken || (e.hit && o.tgt !== e.tgt)) begin
        errors++;
        $display("FAIL %s: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h",
                 e.name, o.hit, o.taken, o.tgt, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_flush();
    pred_t e, o;
    @(negedge clk);
    sel = 1'b0;
    pred_pc = 32'h84;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    upd_pc = 32'h40; upd_ghr = ghr_m0; upd_taken = 1'b1; upd_target = 32'h700;
    upd_mispredict = 1'b1; upd_valid0 = 1'b1;
    checks++;
    if (ready0 !== 1'b0 || hit0 !== 1'b0) begin
      errors++;
      $display("FAIL flush_enter: got ready=%b hit=%b, want 0 0", ready0, hit0);
    end
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ready0 !== (i == 32) || (i < 32 && hit0 !== 1'b0)) begin
        errors++;
        $display("FAIL flush_init edge %0d: got ready=%b hit=%b, want ready=%b hit=0",
                 i, ready0, hit0, (i == 32));
      end
    end
    upd_valid0 = 1'b0;
    checks++;
    if (miss0 !== miss_m0 || ghr0 !== ghr_m0) begin
      errors++;
      $display("FAIL flush_ignored_upd: got miss=%0d ghr=%h, want miss=%0d ghr=%h",
               miss0, ghr0, miss_m0, ghr_m0);
    end
    @(negedge clk);
    drive_pred("flush_cleared40", 32'h40, 1'b0, 1'b0, 32'h0);
    drive_pred("flush_cleared84", 32'h84, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      do_upd(32'h100, ghr_m0, 1'b0, 32'h0, 1'b1);
      ghr_m0 = {ghr_m0[6:0], 1'b0};
      miss_m0++;
    end
    checks++;
    if (miss0 !== miss_m0) begin
      errors++;
      $display("FAIL miss_count: got %0d, want %0d", miss0, miss_m0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.hit !== e.hit || o.taken !== e.taken || (e.hit && o.tgt !== e.tgt)) begin
        errors++;
        $display("FAIL %s: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h",
                 e.name, o.hit, o.taken, o.tgt, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_gshare();
    pred_t e, o;
    @(negedge clk);
    sel = 1'b1;
    for (int i = 0; i < 2; i++) begin
      do_upd(32'h40, 8'h01, 1'b1, 32'h100, 1'b0);
      ghr_m1 = {ghr_m1[6:0], 1'b1};
    end
    checks++;
    if (ghr1 !== ghr_m1) begin
      errors++;
      $display("FAIL gshare_ghr_taken: got %h, want %h", ghr1, ghr_m1);
    end
    // Shift the live history back to zero through an unrelated entry.
    for (int i = 0; i < 8; i++) begin
      do_upd(32'h0, 8'h00, 1'b0, 32'h0, 1'b0);
      ghr_m1 = {ghr_m1[6:0], 1'b0};
    end
    checks++;
    if (ghr1 !== ghr_m1) begin
      errors++;
      $display("FAIL gshare_ghr_clear: got %h, want %h", ghr1, ghr_m1);
    end
    drive_pred("gshare_ghr00", 32'h40, 1'b1, 1'b0, 32'h100);
    @(negedge clk);
    do_upd(32'h0, 8'h00, 1'b1, 32'h500, 1'b0);
    ghr_m1 = {ghr_m1[6:0], 1'b1};
    drive_pred("gshare_ghr01", 32'h40, 1'b1, 1'b1, 32'h100);
    sel = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.hit !== e.hit || o.taken !== e.taken || (e.hit && o.tgt !== e.tgt)) begin
        errors++;
        $display("FAIL %s: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h",
                 e.name, o.hit, o.taken, o.tgt, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bimodal();
    test_saturation();
    test_alias();
    test_back_to_back();
    test_flush();
    test_gshare();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
